trace_unpacker: RTL and testbench

- Consumer end of the core's 3-lane retire trace packet (valid/insn/address/exception/ecause/interrupt/tval).
- Buffers whole retire packets in a small FIFO and replays them as one instruction record per cycle over a valid/ready stream.
- Feeds the debug/trace sink. Retire cannot stall, so FIFO overflow drops whole packets and counts the drops.

---
 rtl/trace_unpacker.sv | 194 +++++++++++++++++++
 tb/tb_trace_unpacker.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/trace_unpacker.sv
// trace_unpacker: consumer end of the 3-lane retire trace packet.
// Whole retire packets are buffered in a DEPTH-entry FIFO and replayed as
// one instruction record per cycle over a valid/ready stream. Retire cannot
// stall, so a packet that finds the FIFO full is dropped whole and counted.
// Optional feature: define RV_TRACE_TIMESTAMP_EN to add out_timestamp, a
// free-running TS_W cycle counter sampled into each entry at push time.
`timescale 1ns/1ps
module trace_unpacker #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16,
   parameter int TS_W  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       trace_rv_i_valid_ip,
   input  logic [95:0]      trace_rv_i_insn_ip,
   input  logic [95:0]      trace_rv_i_address_ip,
   input  logic [2:0]       trace_rv_i_exception_ip,
   input  logic [4:0]       trace_rv_i_ecause_ip,
   input  logic [2:0]       trace_rv_i_interrupt_ip,
   input  logic [31:0]      trace_rv_i_tval_ip,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_lane,
   output logic [31:0]      out_insn,
   output logic [31:0]      out_addr,
   output logic             out_exception,
   output logic             out_interrupt,
   output logic [4:0]       out_ecause,
   output logic [31:0]      out_tval,
`ifdef RV_TRACE_TIMESTAMP_EN
   output logic [TS_W-1:0]  out_timestamp,
`endif
   output logic             fifo_empty,
   output logic             overflow,
   output logic [CNT_W-1:0] drop_cnt,
   input  logic             clr_overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   // Lowest remaining lane of a packet mask; records leave in lane order.
   function automatic logic [1:0] low_lane(input logic [2:0] mask);
      if (mask[0])      return 2'd0;
      else if (mask[1]) return 2'd1;
      else if (mask[2]) return 2'd2;
      else              return 2'd0;
   endfunction

   // Select the 32-bit word of one lane from a 3-lane packed field.
   function automatic logic [31:0] lane_word(input logic [95:0] bus, input logic [1:0] lane);
      case (lane)
         2'd1:    return bus[63:32];
         2'd2:    return bus[95:64];
         default: return bus[31:0];
      endcase
   endfunction

   // Saturating increment for the drop counter.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
      if (&val) return val;
      else      return val + 1'b1;
   endfunction

   // Per-entry control (mask) and payload storage.
   logic [2:0]  mask_mem   [DEPTH];
   logic [95:0] insn_mem   [DEPTH];
   logic [95:0] addr_mem   [DEPTH];
   logic [2:0]  exc_mem    [DEPTH];
   logic [2:0]  intr_mem   [DEPTH];
   logic [4:0]  ecause_mem [DEPTH];
   logic [31:0] tval_mem   [DEPTH];

   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   count;

   logic [2:0] head_mask;
   logic [1:0] head_lane;
   logic [2:0] lane_bit;
   logic [2:0] rest_mask;
   logic       handshake;
   logic       pop;
   logic       push_req;
   logic       push;
   logic       drop;

   // Head-of-queue decode and push/pop/drop decisions.
   always_comb begin
      head_mask = mask_mem[rd_ptr];
      head_lane = low_lane(head_mask);
      lane_bit  = 3'b001 << head_lane;
      rest_mask = head_mask & ~lane_bit;
      out_valid = (count != '0);
      fifo_empty = (count == '0);
      handshake = out_valid & out_ready;
      pop       = handshake & (rest_mask == 3'b000);
      push_req  = |trace_rv_i_valid_ip;
      // A full FIFO still accepts when the head retires its last lane now.
      push      = push_req & ((count != FULL_CNT) | pop);
      drop      = push_req & ~push;
   end

   // Record fields from the head entry; everything reads zero while empty.
   always_comb begin
      out_lane      = 2'd0;
      out_insn      = 32'd0;
      out_addr      = 32'd0;
      out_exception = 1'b0;
      out_interrupt = 1'b0;
      out_ecause    = 5'd0;
      out_tval      = 32'd0;
      if (out_valid) begin
         out_lane      = head_lane;
         out_insn      = lane_word(insn_mem[rd_ptr], head_lane);
         out_addr      = lane_word(addr_mem[rd_ptr], head_lane);
         out_exception = |(exc_mem[rd_ptr] & lane_bit);
         out_interrupt = |(intr_mem[rd_ptr] & lane_bit);
         // Shared cause/tval belong only to the lane that trapped.
         if (out_exception || out_interrupt) begin
            out_ecause = ecause_mem[rd_ptr];
            out_tval   = tval_mem[rd_ptr];
         end
      end
   end

   // Pointers, occupancy and lane masks; a push into the popping slot wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mask_mem[i] <= 3'b000;
      end else begin
         if (handshake) mask_mem[rd_ptr] <= rest_mask;
         if (push) begin
            mask_mem[wr_ptr] <= trace_rv_i_valid_ip;
            wr_ptr           <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Payload capture; storage is qualified by the masks so needs no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         insn_mem[wr_ptr]   <= trace_rv_i_insn_ip;
         addr_mem[wr_ptr]   <= trace_rv_i_address_ip;
         exc_mem[wr_ptr]    <= trace_rv_i_exception_ip;
         intr_mem[wr_ptr]   <= trace_rv_i_interrupt_ip;
         ecause_mem[wr_ptr] <= trace_rv_i_ecause_ip;
         tval_mem[wr_ptr]   <= trace_rv_i_tval_ip;
      end
   end

   // Sticky overflow and saturating drop count; a drop beats a clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         drop_cnt <= clr_overflow ? CNT_W'(1) : sat_inc(drop_cnt);
      end else if (clr_overflow) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end
   end

`ifdef RV_TRACE_TIMESTAMP_EN
   logic [TS_W-1:0] ts_cnt;
   logic [TS_W-1:0] ts_mem [DEPTH];

   // Free-running cycle counter, wraps naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ts_cnt <= '0;
      else     ts_cnt <= ts_cnt + 1'b1;
   end

   // Each accepted packet records the counter value of its push cycle.
   always_ff @(posedge clk) begin
      if (push) ts_mem[wr_ptr] <= ts_cnt;
   end

   assign out_timestamp = out_valid ? ts_mem[rd_ptr] : '0;
`endif

endmodule

// File: tb/tb_trace_unpacker.sv
// Directed bench for trace_unpacker (DEPTH=4, CNT_W=2 so saturation is reachable).
`timescale 1ns/1ps
module tb_trace_unpacker;

   localparam int DEPTH = 4;
   localparam int CNT_W = 2;
   localparam int TS_W  = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic [2:0]       v_ip;
   logic [95:0]      insn_ip;
   logic [95:0]      addr_ip;
   logic [2:0]       exc_ip;
   logic [4:0]       ecause_ip;
   logic [2:0]       intr_ip;
   logic [31:0]      tval_ip;
   logic             out_valid;
   logic             out_ready;
   logic [1:0]       out_lane;
   logic [31:0]      out_insn;
   logic [31:0]      out_addr;
   logic             out_exception;
   logic             out_interrupt;
   logic [4:0]       out_ecause;
   logic [31:0]      out_tval;
   logic             fifo_empty;
   logic             overflow;
   logic [CNT_W-1:0] drop_cnt;
   logic             clr_overflow;
`ifdef RV_TRACE_TIMESTAMP_EN
   logic [TS_W-1:0]  out_timestamp;
`endif

   int checks = 0;
   int errors = 0;

   trace_unpacker #(.DEPTH(DEPTH), .CNT_W(CNT_W), .TS_W(TS_W)) dut (
      .clk                     (clk),
      .rst                     (rst),
      .trace_rv_i_valid_ip     (v_ip),
      .trace_rv_i_insn_ip      (insn_ip),
      .trace_rv_i_address_ip   (addr_ip),
      .trace_rv_i_exception_ip (exc_ip),
      .trace_rv_i_ecause_ip    (ecause_ip),
      .trace_rv_i_interrupt_ip (intr_ip),
      .trace_rv_i_tval_ip      (tval_ip),
      .out_valid               (out_valid),
      .out_ready               (out_ready),
      .out_lane                (out_lane),
      .out_insn                (out_insn),
      .out_addr                (out_addr),
      .out_exception           (out_exception),
      .out_interrupt           (out_interrupt),
      .out_ecause              (out_ecause),
      .out_tval                (out_tval),
`ifdef RV_TRACE_TIMESTAMP_EN
      .out_timestamp           (out_timestamp),
`endif
      .fifo_empty              (fifo_empty),
      .overflow                (overflow),
      .drop_cnt                (drop_cnt),
      .clr_overflow            (clr_overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      v_ip = 3'b000; insn_ip = '0; addr_ip = '0; exc_ip = 3'b000;
      ecause_ip = 5'd0; intr_ip = 3'b000; tval_ip = 32'd0;
   endtask

   task automatic single(input logic [31:0] insn);
      idle();
      v_ip = 3'b001;
      insn_ip = {64'd0, insn};
      addr_ip = {64'd0, insn << 2};
   endtask

   initial begin
      rst = 1'b1; out_ready = 1'b0; clr_overflow = 1'b0;
      idle();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // reset state
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_empty", 32'(fifo_empty), 32'd1);
      check("rst_ovf", 32'(overflow), 32'd0);
      check("rst_drop", 32'(drop_cnt), 32'd0);
      check("rst_insn", out_insn, 32'd0);

      // lane sequencing, lane 1 absent
      v_ip = 3'b101;
      insn_ip = {32'h33, 32'h22, 32'h11};
      addr_ip = {32'h108, 32'h104, 32'h100};
      out_ready = 1'b1;
      tick(); idle();
      check("seq0_valid", 32'(out_valid), 32'd1);
      check("seq0_lane", 32'(out_lane), 32'd0);
      check("seq0_insn", out_insn, 32'h11);
      check("seq0_addr", out_addr, 32'h100);
      tick();
      check("seq1_lane", 32'(out_lane), 32'd2);
      check("seq1_insn", out_insn, 32'h33);
      check("seq1_addr", out_addr, 32'h108);
      tick();
      check("seq_end_valid", 32'(out_valid), 32'd0);
      check("seq_end_empty", 32'(fifo_empty), 32'd1);

      // backpressure overflow: 6 pushes into 4 entries
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         single(32'h200 + 32'(i));
         tick();
      end
      idle();
      check("bp_ovf", 32'(overflow), 32'd1);
      check("bp_drop", 32'(drop_cnt), 32'd2);
      tick();
      check("bp_hold_insn", out_insn, 32'h200);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("bp_valid", 32'(out_valid), 32'd1);
         check("bp_insn", out_insn, 32'h200 + 32'(i));
         tick();
      end
      check("bp_empty", 32'(fifo_empty), 32'd1);

      // full with same-cycle pop
      clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
      check("clr_ovf", 32'(overflow), 32'd0);
      check("clr_drop", 32'(drop_cnt), 32'd0);
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         single(32'h300 + 32'(i));
         tick();
      end
      single(32'h304);
      out_ready = 1'b1;
      tick(); idle();
      out_ready = 1'b0;
      check("fp_drop", 32'(drop_cnt), 32'd0);
      check("fp_ovf", 32'(overflow), 32'd0);
      check("fp_head", out_insn, 32'h301);
      single(32'h3ff);
      tick(); idle();
      check("fp_still_full", 32'(drop_cnt), 32'd1);
      out_ready = 1'b1;
      for (int i = 1; i < 5; i++) begin
         check("fp_insn", out_insn, 32'h300 + 32'(i));
         tick();
      end
      check("fp_empty", 32'(fifo_empty), 32'd1);
      clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;

      // exception tagging
      v_ip = 3'b011;
      insn_ip = {32'd0, 32'h4422, 32'h4411};
      addr_ip = {32'd0, 32'h204, 32'h200};
      exc_ip = 3'b010; ecause_ip = 5'd2; tval_ip = 32'hDEADBEEF;
      tick(); idle();
      check("ex0_exc", 32'(out_exception), 32'd0);
      check("ex0_cause", 32'(out_ecause), 32'd0);
      check("ex0_tval", out_tval, 32'd0);
      tick();
      check("ex1_lane", 32'(out_lane), 32'd1);
      check("ex1_exc", 32'(out_exception), 32'd1);
      check("ex1_cause", 32'(out_ecause), 32'd2);
      check("ex1_tval", out_tval, 32'hDEADBEEF);
      tick();
      check("ex_empty", 32'(out_valid), 32'd0);
      single(32'h5151);
      intr_ip = 3'b001; ecause_ip = 5'd7; tval_ip = 32'h55;
      tick(); idle();
      check("irq_flag", 32'(out_interrupt), 32'd1);
      check("irq_exc", 32'(out_exception), 32'd0);
      check("irq_cause", 32'(out_ecause), 32'd7);
      check("irq_tval", out_tval, 32'h55);
      tick();

      // saturation and clear-versus-drop
      out_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         single(32'h500 + 32'(i));
         tick();
      end
      idle();
      check("sat_drop", 32'(drop_cnt), 32'd3);
      check("sat_ovf", 32'(overflow), 32'd1);
      single(32'h5ff);
      clr_overflow = 1'b1;
      tick(); idle();
      check("clrdrop_ovf", 32'(overflow), 32'd1);
      check("clrdrop_cnt", 32'(drop_cnt), 32'd1);
      tick(); clr_overflow = 1'b0;
      check("clr2_ovf", 32'(overflow), 32'd0);
      check("clr2_cnt", 32'(drop_cnt), 32'd0);

      // reset mid-drain with 3 packets buffered
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      check("pre_rst_insn", out_insn, 32'h501);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_empty", 32'(fifo_empty), 32'd1);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) tick();
      single(32'h600);
      tick(); idle();
      check("post_rst_insn", out_insn, 32'h600);
      check("post_rst_lane", 32'(out_lane), 32'd0);
`ifdef RV_TRACE_TIMESTAMP_EN
      check("post_rst_ts", out_timestamp, 32'd2);
`endif
      out_ready = 1'b1;
      tick();
      check("post_rst_empty", 32'(fifo_empty), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
